sw_debounce: RTL and testbench
==============================

# sw_debounce

Per-bit switch/button conditioner that sits directly upstream of the Qsys PIO input port (`in_port`) reading board switches. Each raw, asynchronous pin is synchronized into `clk`, debounced with a per-bit saturating counter, and presented as a clean level; optional one-cycle edge pulses are also generated. The PIO therefore sees only stable, glitch-free, clock-domain-safe levels.

## Interface
- `WIDTH`, 1, number of independent switch bits.
- `DEBOUNCE_CYCLES`, 50000, cycles N a synchronized level must hold before acceptance; legal range 1..2^20.
- `RESET_VAL`, 0, WIDTH-bit reset value of synchronizer and stable registers.
- `clk  input  1  system clock`
- `reset_n  input  1  asynchronous, active-low reset`
- `sw_raw  input  WIDTH  raw asynchronous switch pins`
- `sw_out  output  WIDTH  debounced level; drives PIO in_port`
- `rise_pulse  output  WIDTH  one-cycle pulse on accepted 0->1 (see Configuration)`
- `fall_pulse  output  WIDTH  one-cycle pulse on accepted 1->0 (see Configuration)`

## Operation
- Per bit i, fully independent datapath: `sync1[i]` -> `sync2[i]` (2-flop synchronizer), `stable[i]`, counter `cnt[i]` of width clog2(DEBOUNCE_CYCLES+1).
- `sw_out = stable` (registered, no combinational path from `sw_raw`).
- Each edge, per bit:
  - `sync2 == stable`: `cnt <= 0`.
  - `sync2 != stable` and `cnt == N-1`: `stable <= sync2`, `cnt <= 0`, pulse registered for this edge.
  - `sync2 != stable` otherwise: `cnt <= cnt + 1`.
- Any return of `sync2` to `stable` before acceptance clears `cnt` (glitch rejected, no partial credit).
- Counter never exceeds N-1; no wrap-around possible.
- Pulses: `rise_pulse[i] <= accept & sync2[i]`, `fall_pulse[i] <= accept & ~sync2[i]`; both deasserted every other edge. Never both high on one bit.
- Reset (asynchronous, any time, including mid-count): `sync1`, `sync2`, `stable` <= `RESET_VAL`; `cnt` <= 0; `rise_pulse`, `fall_pulse` <= 0. Hence `sw_out` resets to `RESET_VAL`. Release does not emit pulses even if pins differ from `RESET_VAL`; pins then debounce normally (full N cycles).

## Timing
- Pin settles before edge k (sampled into `sync1` at edge k) and holds: `sync2` updates at edge k+1, `sw_out` and pulse update at edge k+N+1. Total latency N+2 edges counting edge k.
- N=1: `sw_out` changes at edge k+2 (synchronizer latency only).
- Pulse width exactly one `clk` cycle, aligned with the `sw_out` transition.
- A `sync2` disturbance lasting <= N-1 cycles never changes `sw_out`.
- Metastability confined to `sync1`; `sync1` marked as synchronizer for timing analysis.

## Configuration
- `SW_DEBOUNCE_EDGE_EN` defined: pulse registers and logic present; `rise_pulse`/`fall_pulse` behave as above.
- Undefined: no pulse registers synthesized; `rise_pulse` and `fall_pulse` tied to constant 0; `sw_out` behaviour and latency unchanged.

## Test plan
- Reset: assert `reset_n`=0 mid-count with `RESET_VAL`=0, `sw_raw`=1 -> `sw_out`=0, pulses 0, `cnt`=0 immediately; after release `sw_out`=1 exactly N+2 edges after first sample, no pulse at release.
- Clean press, WIDTH=1, N=4: `sw_raw` 0->1 before edge 10 -> `sw_out`=1 and `rise_pulse`=1 after edge 15, `rise_pulse`=0 after edge 16.
- Glitch rejection, N=4: `sw_raw` high for 3 cycles then low -> `sw_out` stays 0, no pulse; high for 4+ cycles -> accepted.
- Bounce: 1,0,1,1,0,1,1,1,1 at N=4 -> single acceptance 4 cycles after last 0 leaves `sync2`, exactly one `rise_pulse`.
- Independence, WIDTH=4: bit0 press, bit2 release simultaneously, bit1 bouncing -> bit0 `rise_pulse` and bit2 `fall_pulse` on same edge, bit1 unchanged, bit3 idle.
- Macro off: repeat clean press -> `sw_out` identical timing, `rise_pulse`/`fall_pulse` constantly 0.

Source files
------------

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit switch conditioner feeding a PIO input port.
// Each raw pin is brought into clk through a two-flop synchronizer, then
// accepted as the new level only after the synchronized value has differed
// from the current stable level for DEBOUNCE_CYCLES consecutive edges.
// Any return to the stable level before that discards the partial count.
//
// Optional feature macro: SW_DEBOUNCE_EDGE_EN
//   defined   : one-cycle rise_pulse/fall_pulse registers aligned with sw_out
//   undefined : rise_pulse/fall_pulse tied to 0, no pulse registers
module sw_debounce #(
   parameter int               WIDTH           = 1,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   localparam int              CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_TC = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);

   // first synchronizer stage: the only flop allowed to go metastable
   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] accept;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];

   // two-flop synchronizer for the asynchronous pins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= RESET_VAL;
         sync2_q <= RESET_VAL;
      end else begin
         sync1_q <= sw_raw;
         sync2_q <= sync1_q;
      end
   end

   // per-bit hold counter: counts consecutive edges with sync2 != stable,
   // accepts at the terminal count, clears on any agreement
   always_comb begin
      stable_d = stable_q;
      accept   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_TC) begin
               accept[i]   = 1'b1;
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // stable level and hold counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable_q <= RESET_VAL;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         stable_q <= stable_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign sw_out = stable_q;

`ifdef SW_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] rise_q;
   logic [WIDTH-1:0] fall_q;
   logic [WIDTH-1:0] rise_d;
   logic [WIDTH-1:0] fall_d;

   // the accepted direction is the value being taken from sync2
   always_comb begin
      rise_d = accept &  sync2_q;
      fall_d = accept & ~sync2_q;
   end

   // edge pulses, high for exactly the cycle sw_out changes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
`else
   assign rise_pulse = '0;
   assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed and random stimulus for two sw_debounce builds
// (4 bits with a 4-cycle hold, 2 bits with a 1-cycle hold and non-zero
// reset value), checked against a sliding-window reference: a bit is
// accepted when its last N synchronized samples all disagree with the
// current stable level.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   localparam int         NA   = 4;
   localparam logic [3:0] RVA  = 4'b0000;
   localparam logic [1:0] RVB  = 2'b10;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] raw_a;
   logic [1:0] raw_b;
   logic [3:0] out_a, rise_a, fall_a;
   logic [1:0] out_b, rise_b, fall_b;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [3:0] s1a, s2a, stab_a, er_a, ef_a;
   logic [3:0] win_a [NA];
   logic [1:0] s1b, s2b, stab_b, er_b, ef_b;

   sw_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(NA), .RESET_VAL(RVA)) u_dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (raw_a),
      .sw_out     (out_a),
      .rise_pulse (rise_a),
      .fall_pulse (fall_a)
   );

   sw_debounce #(.WIDTH(2), .DEBOUNCE_CYCLES(1), .RESET_VAL(RVB)) u_dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .sw_raw     (raw_b),
      .sw_out     (out_b),
      .rise_pulse (rise_b),
      .fall_pulse (fall_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      s1a = RVA; s2a = RVA; stab_a = RVA; er_a = '0; ef_a = '0;
      for (int k = 0; k < NA; k++) win_a[k] = RVA;
      s1b = RVB; s2b = RVB; stab_b = RVB; er_b = '0; ef_b = '0;
   endtask

   // one clock edge of the reference, using the pins as sampled at that edge
   task automatic model_edge();
      logic [3:0] mask_a;
      logic [1:0] mask_b;
      for (int k = 0; k < NA - 1; k++) win_a[k] = win_a[k+1];
      win_a[NA-1] = s2a;
      mask_a = 4'hF;
      for (int k = 0; k < NA; k++) mask_a &= win_a[k] ^ stab_a;
      er_a   = EDGE_EN ? (mask_a &  s2a) : 4'h0;
      ef_a   = EDGE_EN ? (mask_a & ~s2a) : 4'h0;
      stab_a = stab_a ^ mask_a;
      s2a    = s1a;
      s1a    = raw_a;

      mask_b = s2b ^ stab_b;
      er_b   = EDGE_EN ? (mask_b &  s2b) : 2'h0;
      ef_b   = EDGE_EN ? (mask_b & ~s2b) : 2'h0;
      stab_b = stab_b ^ mask_b;
      s2b    = s1b;
      s1b    = raw_b;
   endtask

   task automatic compare_all();
      check("a_out",  32'(out_a),  32'(stab_a));
      check("a_rise", 32'(rise_a), 32'(er_a));
      check("a_fall", 32'(fall_a), 32'(ef_a));
      check("b_out",  32'(out_b),  32'(stab_b));
      check("b_rise", 32'(rise_b), 32'(er_b));
      check("b_fall", 32'(fall_b), 32'(ef_b));
   endtask

   // drive pins mid-cycle, take one edge, compare 1 time unit later
   task automatic step(input logic [3:0] ra, input logic [1:0] rb);
      raw_a = ra;
      raw_b = rb;
      @(posedge clk);
      if (reset_n) model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      int lat;
      int seen;
      int nrise;
      logic [3:0] va;
      logic [1:0] vb;
      int hold;

      reset_n = 1'b0;
      raw_a   = 4'h0;
      raw_b   = RVB;
      model_reset();
      #12;
      check("rst_out_a", 32'(out_a), 32'(RVA));
      check("rst_out_b", 32'(out_b), 32'(RVB));
      check("rst_pulse", 32'({rise_a, fall_a, rise_b, fall_b}), 32'h0);
      reset_n = 1'b1;

      for (int i = 0; i < 4; i++) step(4'h0, RVB);

      // clean press on bit0: sampled at step 1, sw_out changes at step N+2
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         step(4'b0001, 2'b01);
         if (lat == 0 && out_a[0]) lat = i;
      end
      check("press_lat", 32'(lat), 32'(NA + 2));

      // glitch on bit1 of N-1 cycles is rejected
      seen = 0;
      for (int i = 0; i < 3; i++) begin
         step(4'b0011, 2'b01);
         if (out_a[1]) seen = 1;
      end
      for (int i = 0; i < 8; i++) begin
         step(4'b0001, 2'b01);
         if (out_a[1]) seen = 1;
      end
      check("glitch_rej", 32'(seen), 32'd0);

      // N cycles is accepted
      seen = 0;
      for (int i = 0; i < NA; i++) begin
         step(4'b0011, 2'b01);
         if (out_a[1]) seen = 1;
      end
      for (int i = 0; i < 10; i++) begin
         step(4'b0001, 2'b01);
         if (out_a[1]) seen = 1;
      end
      check("glitch_acc", 32'(seen), 32'd1);

      // bounce on bit3: 1,0,1,1,0,1,1,1,1 then hold, a single rise
      begin
         logic [8:0] pat;
         pat = 9'b1_1110_1101;
         nrise = 0;
         for (int i = 0; i < 9; i++) begin
            step({pat[i], 3'b001}, 2'b00);
            nrise += int'(rise_a[3]);
         end
         for (int i = 0; i < 8; i++) begin
            step(4'b1001, 2'b00);
            nrise += int'(rise_a[3]);
         end
         check("bounce_rises", 32'(nrise), EDGE_EN ? 32'd1 : 32'd0);
         check("bounce_out", 32'(out_a[3]), 32'd1);
      end

      // independence: bit0 press and bit2 release together, bit1 bouncing
      for (int i = 0; i < 10; i++) step(4'b0100, 2'b10);
      for (int i = 0; i < 12; i++) step({1'b0, 1'b0, 1'(i % 2), 1'b1}, 2'b11);
      check("indep_out", 32'(out_a), 32'b0001);

      // asynchronous reset in the middle of a count
      step(4'b0000, 2'b01);
      step(4'b0001, 2'b01);
      step(4'b0001, 2'b01);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("rst_mid_out_a", 32'(out_a), 32'(RVA));
      check("rst_mid_out_b", 32'(out_b), 32'(RVB));
      check("rst_mid_pulse", 32'({rise_a, fall_a, rise_b, fall_b}), 32'h0);
      step(4'b0001, 2'b01);
      step(4'b0001, 2'b01);
      #2 reset_n = 1'b1;
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         step(4'b0001, 2'b01);
         if (lat == 0 && out_a[0]) lat = i;
      end
      check("rst_rel_lat", 32'(lat), 32'(NA + 2));

      // random segments of varying hold length to mix glitches and presses
      for (int s = 0; s < 400; s++) begin
         va   = 4'($urandom_range(0, 15));
         vb   = 2'($urandom_range(0, 3));
         hold = $urandom_range(1, 7);
         for (int i = 0; i < hold; i++) begin
            if ($urandom_range(0, 3) == 0) vb = 2'($urandom_range(0, 3));
            step(va, vb);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
